// File: rtl/wb_commit_stage_if.sv
// Memory-stage to write-back handshake and instruction payload bundle.
// The memory stage drives the payload; the commit stage answers with ws_allowin.
interface wb_commit_stage_if #(
  parameter int IDX_W = 4
);
  logic              ms_to_ws_valid;
  logic              ws_allowin;
  logic [31:0]       ms_pc;
  logic [31:0]       ms_result;
  logic [31:0]       ms_badvaddr;
  logic              ms_gr_we;
  logic              ms_cp0_op;
  logic              ms_cp0_we;
  logic [4:0]        ms_dest;
  logic [7:0]        ms_cp0_addr;
  logic              ms_ex;
  logic              ms_refill;
  logic              ms_bd;
  logic              ms_eret;
  logic [4:0]        ms_excode;
  logic              ms_tlbp;
  logic              ms_tlbr;
  logic              ms_tlbwi;
  logic              ms_s1_found;
  logic [IDX_W-1:0]  ms_s1_index;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_result, ms_badvaddr, ms_gr_we, ms_cp0_op,
           ms_cp0_we, ms_dest, ms_cp0_addr, ms_ex, ms_refill, ms_bd, ms_eret,
           ms_excode, ms_tlbp, ms_tlbr, ms_tlbwi, ms_s1_found, ms_s1_index,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_result, ms_badvaddr, ms_gr_we, ms_cp0_op,
           ms_cp0_we, ms_dest, ms_cp0_addr, ms_ex, ms_refill, ms_bd, ms_eret,
           ms_excode, ms_tlbp, ms_tlbr, ms_tlbwi, ms_s1_found, ms_s1_index,
    output ws_allowin
  );
endinterface

// File: rtl/wb_commit_stage.sv
// MIPS write-back/commit stage: retires one held instruction per cycle, waits
// out the synchronous TLB read for TLBR, and issues a registered redirect pulse.
module wb_commit_stage #(
  parameter int          TLBNUM     = 16,
  parameter int          TLB_RD_LAT = 1,
  parameter logic [31:0] EX_VEC     = 32'hbfc00380,
  parameter logic [31:0] REFILL_VEC = 32'hbfc00200,
  localparam int         IDX_W      = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              reset,
  wb_commit_stage_if.slave  ms,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              mtc0_we,
  output logic [7:0]        c0_addr,
  output logic [31:0]       c0_wdata,
  input  logic [31:0]       c0_rdata,
  output logic              wb_ex,
  output logic              wb_bd,
  output logic              wb_eret,
  output logic [4:0]        ex_type,
  output logic [31:0]       wb_pc,
  output logic [31:0]       wb_badvaddr,
  input  logic [31:0]       cp0_epc,
  input  logic [31:0]       cp0_index,
  output logic              tlb_we,
  output logic [IDX_W-1:0]  tlb_w_index,
  output logic [IDX_W-1:0]  tlb_r_index,
  input  logic [77:0]       tlb_rdata,
  output logic              tlbr_we,
  output logic [77:0]       tlbr_data,
  output logic              tlbp_we,
  output logic              tlbp_p,
  output logic [IDX_W-1:0]  tlbp_index,
  output logic              flush,
  output logic [31:0]       flush_pc,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      result;
    logic [31:0]      badvaddr;
    logic             gr_we;
    logic             cp0_op;
    logic             cp0_we;
    logic [4:0]       dest;
    logic [7:0]       cp0_addr;
    logic             ex;
    logic             refill;
    logic             bd;
    logic             eret;
    logic [4:0]       excode;
    logic             tlbp;
    logic             tlbr;
    logic             tlbwi;
    logic             s1_found;
    logic [IDX_W-1:0] s1_index;
  } payload_t;

  typedef enum logic {IDLE, WAIT} state_t;

  function automatic logic [31:0] redirect_pc(input payload_t p, input logic [31:0] epc);
    if (p.ex && p.refill) return REFILL_VEC;
    if (p.ex)             return EX_VEC;
    if (p.eret)           return epc;
    return p.pc + 32'd4;
  endfunction

  state_t      state_q;
  logic [1:0]  cnt_q;
  payload_t    pl_q, pl_d, pl_in;
  logic        ws_valid_q, ws_valid_d;
  logic        flush_q, flush_d;
  logic [31:0] flush_pc_q, flush_pc_d;
  logic        ready_go, retire, allowin, load, flush_src, commit_ok;

  always_comb begin
    pl_in = '{pc: ms.ms_pc, result: ms.ms_result, badvaddr: ms.ms_badvaddr,
              gr_we: ms.ms_gr_we, cp0_op: ms.ms_cp0_op, cp0_we: ms.ms_cp0_we,
              dest: ms.ms_dest, cp0_addr: ms.ms_cp0_addr, ex: ms.ms_ex,
              refill: ms.ms_refill, bd: ms.ms_bd, eret: ms.ms_eret,
              excode: ms.ms_excode, tlbp: ms.ms_tlbp, tlbr: ms.ms_tlbr,
              tlbwi: ms.ms_tlbwi, s1_found: ms.ms_s1_found,
              s1_index: ms.ms_s1_index};
    ready_go  = !((state_q == WAIT) && (cnt_q != 2'd0));
    retire    = ws_valid_q && ready_go;
    allowin   = !ws_valid_q || retire;
    flush_src = retire && (pl_q.ex || pl_q.eret || pl_q.tlbr || pl_q.tlbwi);
    // A redirecting retire kills whatever is offered now and in the flush cycle.
    load      = ms.ms_to_ws_valid && allowin && !flush_q && !flush_src;
    pl_d      = load ? pl_in : pl_q;
    ws_valid_d = ws_valid_q;
    if (flush_q)     ws_valid_d = 1'b0;
    else if (load)   ws_valid_d = 1'b1;
    else if (retire) ws_valid_d = 1'b0;
    flush_d    = flush_src;
    flush_pc_d = flush_src ? redirect_pc(pl_q, cp0_epc) : flush_pc_q;
    commit_ok  = retire && !pl_q.ex;
  end

  // Stage boundary: held instruction and redirect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      flush_pc_q <= 32'd0;
    end else begin
      ws_valid_q <= ws_valid_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    pl_q <= pl_d;
  end

  // TLBR read sequencer: entered as the TLBR is loaded, counts down the read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load && ms.ms_tlbr && !ms.ms_ex) begin
            state_q <= WAIT;
            cnt_q   <= 2'(TLB_RD_LAT);
          end
        end
        WAIT: begin
          if (cnt_q != 2'd0) cnt_q   <= cnt_q - 2'd1;
          else               state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ms.ws_allowin = allowin;

  assign rf_we       = commit_ok && pl_q.gr_we;
  assign rf_waddr    = pl_q.dest;
  assign rf_wdata    = pl_q.cp0_op ? c0_rdata : pl_q.result;
  assign mtc0_we     = commit_ok && pl_q.cp0_we;
  assign c0_addr     = pl_q.cp0_addr;
  assign c0_wdata    = pl_q.result;
  assign wb_ex       = retire && pl_q.ex;
  assign wb_bd       = pl_q.bd;
  assign wb_eret     = commit_ok && pl_q.eret;
  assign ex_type     = pl_q.excode;
  assign wb_pc       = pl_q.pc;
  assign wb_badvaddr = pl_q.badvaddr;
  assign tlb_we      = commit_ok && pl_q.tlbwi;
  assign tlb_w_index = cp0_index[IDX_W-1:0];
  assign tlb_r_index = cp0_index[IDX_W-1:0];
  assign tlbr_we     = commit_ok && pl_q.tlbr;
  assign tlbr_data   = tlb_rdata;
  assign tlbp_we     = commit_ok && pl_q.tlbp;
  assign tlbp_p      = !pl_q.s1_found;
  assign tlbp_index  = pl_q.s1_index;
  assign flush       = flush_q;
  assign flush_pc    = flush_pc_q;

  assign debug_wb_pc       = pl_q.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: vector table, hand-written multi-cycle sequences,
// and random traffic checked against a cycle-count reference model.
module tb_wb_commit_stage;
  localparam int          IDX_W = 4;
  localparam int          LAT   = 2;
  localparam logic [31:0] EXV   = 32'hbfc00380;
  localparam logic [31:0] RFV   = 32'hbfc00200;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_commit_stage_if #(.IDX_W(IDX_W)) ms_if();

  logic             rf_we, mtc0_we, wb_ex, wb_bd, wb_eret, tlb_we, tlbr_we, tlbp_we, tlbp_p, flush;
  logic [4:0]       rf_waddr, ex_type, debug_wb_rf_wnum;
  logic [31:0]      rf_wdata, c0_wdata, c0_rdata, wb_pc, wb_badvaddr, cp0_epc, cp0_index;
  logic [31:0]      flush_pc, debug_wb_pc, debug_wb_rf_wdata;
  logic [7:0]       c0_addr;
  logic [IDX_W-1:0] tlb_w_index, tlb_r_index, tlbp_index;
  logic [77:0]      tlb_rdata, tlbr_data;
  logic [3:0]       debug_wb_rf_wen;

  wb_commit_stage #(.TLBNUM(16), .TLB_RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .ms(ms_if.slave),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mtc0_we(mtc0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_rdata(c0_rdata),
    .wb_ex(wb_ex), .wb_bd(wb_bd), .wb_eret(wb_eret), .ex_type(ex_type),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .cp0_epc(cp0_epc), .cp0_index(cp0_index),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_r_index(tlb_r_index),
    .tlb_rdata(tlb_rdata), .tlbr_we(tlbr_we), .tlbr_data(tlbr_data),
    .tlbp_we(tlbp_we), .tlbp_p(tlbp_p), .tlbp_index(tlbp_index),
    .flush(flush), .flush_pc(flush_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      result;
    logic [4:0]       dest;
    logic             gr_we, cp0_op, cp0_we, ex, refill, eret, tlbp, tlbr, tlbwi, s1_found;
    logic [IDX_W-1:0] s1_index;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic [31:0] c0;
    logic        e_rf_we;
    logic [31:0] e_wdata;
    logic        e_mtc0, e_tlb_we, e_tlbp_we, e_tlbp_p, e_wb_ex, e_wb_eret, e_flush;
    logic [31:0] e_fpc;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t i, input logic v);
    ms_if.ms_to_ws_valid = v;
    ms_if.ms_pc          = i.pc;
    ms_if.ms_result      = i.result;
    ms_if.ms_badvaddr    = i.pc ^ 32'h0000_ffff;
    ms_if.ms_gr_we       = i.gr_we;
    ms_if.ms_cp0_op      = i.cp0_op;
    ms_if.ms_cp0_we      = i.cp0_we;
    ms_if.ms_dest        = i.dest;
    ms_if.ms_cp0_addr    = {i.dest, 3'b000};
    ms_if.ms_ex          = i.ex;
    ms_if.ms_refill      = i.refill;
    ms_if.ms_bd          = 1'b0;
    ms_if.ms_eret        = i.eret;
    ms_if.ms_excode      = i.ex ? 5'd2 : 5'd0;
    ms_if.ms_tlbp        = i.tlbp;
    ms_if.ms_tlbr        = i.tlbr;
    ms_if.ms_tlbwi       = i.tlbwi;
    ms_if.ms_s1_found    = i.s1_found;
    ms_if.ms_s1_index    = i.s1_index;
  endtask

  function automatic instr_t rnd_instr();
    instr_t i;
    i.pc       = $urandom & 32'hffff_fffc;
    i.result   = $urandom;
    i.dest     = 5'($urandom);
    i.gr_we    = 1'($urandom_range(0, 1));
    i.cp0_op   = ($urandom_range(0, 3) == 0);
    i.cp0_we   = ($urandom_range(0, 5) == 0);
    i.ex       = ($urandom_range(0, 7) == 0);
    i.refill   = 1'($urandom_range(0, 1));
    i.eret     = ($urandom_range(0, 9) == 0);
    i.tlbp     = ($urandom_range(0, 6) == 0);
    i.tlbr     = ($urandom_range(0, 5) == 0);
    i.tlbwi    = ($urandom_range(0, 9) == 0);
    i.s1_found = 1'($urandom_range(0, 1));
    i.s1_index = IDX_W'($urandom);
    return i;
  endfunction

  vec_t   vt[11];
  instr_t nop, ti, held, nx;
  logic [77:0] rd;
  bit     have, retiring, v, ok_in;
  int     cyc, ret_cyc, drop_until, flush_cyc;
  logic [31:0] exp_fpc;

  initial begin
    nop = '0;
    // pc, result, dest, gr_we, cp0_op, cp0_we, ex, refill, eret, tlbp, tlbr, tlbwi, s1_found, s1_index
    vt[0]  = '{'{32'h100, 32'h1234, 5'd5, 1,0,0, 0,0,0, 0,0,0, 0, 4'd0}, 32'h0,
               1, 32'h1234, 0,0,0,0, 0,0,0, 32'h0};
    vt[1]  = '{'{32'h104, 32'h1111_1111, 5'd3, 1,1,0, 0,0,0, 0,0,0, 0, 4'd0}, 32'hdead_beef,
               1, 32'hdead_beef, 0,0,0,0, 0,0,0, 32'h0};
    vt[2]  = '{'{32'h108, 32'h55, 5'd12, 0,0,1, 0,0,0, 0,0,0, 0, 4'd0}, 32'h0,
               0, 32'h0, 1,0,0,0, 0,0,0, 32'h0};
    vt[3]  = '{'{32'h8000_0100, 32'h9, 5'd4, 1,0,0, 1,1,0, 0,0,0, 0, 4'd0}, 32'h0,
               0, 32'h0, 0,0,0,0, 1,0,1, RFV};
    vt[4]  = '{'{32'h8000_0200, 32'h77, 5'd2, 1,0,1, 1,0,0, 0,0,0, 0, 4'd0}, 32'h0,
               0, 32'h0, 0,0,0,0, 1,0,1, EXV};
    vt[5]  = '{'{32'h8000_0300, 32'h0, 5'd0, 0,0,0, 0,0,1, 0,0,0, 0, 4'd0}, 32'h0,
               0, 32'h0, 0,0,0,0, 0,1,1, 32'hbfc0_1000};
    vt[6]  = '{'{32'h8000_0400, 32'h0, 5'd0, 0,0,0, 0,0,0, 1,0,0, 0, 4'd4}, 32'h0,
               0, 32'h0, 0,0,1,1, 0,0,0, 32'h0};
    vt[7]  = '{'{32'h8000_0404, 32'h0, 5'd0, 0,0,0, 0,0,0, 1,0,0, 1, 4'd9}, 32'h0,
               0, 32'h0, 0,0,1,0, 0,0,0, 32'h0};
    vt[8]  = '{'{32'h2000, 32'h0, 5'd0, 0,0,0, 0,0,0, 0,0,1, 0, 4'd0}, 32'h0,
               0, 32'h0, 0,1,0,0, 0,0,1, 32'h2004};
    vt[9]  = '{'{32'h8000_0500, 32'h0, 5'd0, 0,0,0, 1,0,1, 0,0,0, 0, 4'd0}, 32'h0,
               0, 32'h0, 0,0,0,0, 1,0,1, EXV};
    vt[10] = '{'{32'h2100, 32'h0, 5'd0, 0,0,0, 1,1,0, 0,0,1, 0, 4'd0}, 32'h0,
               0, 32'h0, 0,0,0,0, 1,0,1, RFV};

    reset = 1'b1; c0_rdata = '0; cp0_epc = 32'hbfc0_1000; cp0_index = 32'd7; tlb_rdata = '0;
    drive(nop, 1'b0);
    tick(); tick();
    chk("rst_allowin", ms_if.ws_allowin, 1'b1);
    chk("rst_flush", flush, 1'b0);
    chk("rst_flush_pc", flush_pc, 32'h0);
    chk("rst_strobes", {rf_we, mtc0_we, tlb_we, tlbr_we, tlbp_we, wb_ex, wb_eret}, 7'h0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 11; k++) begin
      c0_rdata = vt[k].c0;
      drive(vt[k].in, 1'b1);
      tick();
      ms_if.ms_to_ws_valid = 1'b0;
      chk($sformatf("v%0d_rf_we", k), rf_we, vt[k].e_rf_we);
      if (vt[k].e_rf_we) begin
        chk($sformatf("v%0d_rf_wdata", k), rf_wdata, vt[k].e_wdata);
        chk($sformatf("v%0d_rf_waddr", k), rf_waddr, vt[k].in.dest);
      end
      chk($sformatf("v%0d_mtc0_we", k), mtc0_we, vt[k].e_mtc0);
      if (vt[k].e_mtc0) chk($sformatf("v%0d_c0_wdata", k), c0_wdata, vt[k].in.result);
      chk($sformatf("v%0d_tlb_we", k), tlb_we, vt[k].e_tlb_we);
      if (vt[k].e_tlb_we) chk($sformatf("v%0d_tlb_w_index", k), tlb_w_index, 4'd7);
      chk($sformatf("v%0d_tlbp_we", k), tlbp_we, vt[k].e_tlbp_we);
      if (vt[k].e_tlbp_we) begin
        chk($sformatf("v%0d_tlbp_p", k), tlbp_p, vt[k].e_tlbp_p);
        chk($sformatf("v%0d_tlbp_index", k), tlbp_index, vt[k].in.s1_index);
      end
      chk($sformatf("v%0d_wb_ex", k), wb_ex, vt[k].e_wb_ex);
      chk($sformatf("v%0d_wb_eret", k), wb_eret, vt[k].e_wb_eret);
      chk($sformatf("v%0d_flush_now", k), flush, 1'b0);
      tick();
      chk($sformatf("v%0d_flush", k), flush, vt[k].e_flush);
      if (vt[k].e_flush) chk($sformatf("v%0d_flush_pc", k), flush_pc, vt[k].e_fpc);
      tick();
    end

    // Back-to-back ADDU, one retire per cycle.
    ti = nop; ti.gr_we = 1'b1; ti.dest = 5'd5; ti.result = 32'h1234; ti.pc = 32'h400;
    drive(ti, 1'b1);
    tick();
    chk("b2b_rf_we0", rf_we, 1'b1);
    chk("b2b_waddr0", rf_waddr, 5'd5);
    chk("b2b_wen0", debug_wb_rf_wen, 4'hf);
    ti.dest = 5'd6; ti.pc = 32'h404;
    drive(ti, 1'b1);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    chk("b2b_rf_we1", rf_we, 1'b1);
    chk("b2b_waddr1", debug_wb_rf_wnum, 5'd6);
    chk("b2b_wpc1", debug_wb_pc, 32'h404);
    tick();
    chk("b2b_idle", rf_we, 1'b0);
    chk("b2b_noflush", flush, 1'b0);

    // Refill exception, then input offered during the flush cycle is dropped.
    ti = nop; ti.gr_we = 1'b1; ti.ex = 1'b1; ti.refill = 1'b1; ti.pc = 32'h8000_0100; ti.dest = 5'd8;
    drive(ti, 1'b1);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    chk("exd_wb_ex", wb_ex, 1'b1);
    chk("exd_rf_we", rf_we, 1'b0);
    chk("exd_wb_pc", wb_pc, 32'h8000_0100);
    tick();
    chk("exd_flush", flush, 1'b1);
    chk("exd_flush_pc", flush_pc, RFV);
    ti = nop; ti.gr_we = 1'b1; ti.dest = 5'd9;
    drive(ti, 1'b1);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    chk("exd_dropped", rf_we, 1'b0);
    chk("exd_flush_once", flush, 1'b0);
    tick();

    // TLBR waits LAT cycles for the synchronous TLB read.
    cp0_index = 32'd7;
    rd = 78'h2a_5a5a_1234_5678_9abc;
    tlb_rdata = rd;
    ti = nop; ti.tlbr = 1'b1; ti.pc = 32'h3000;
    drive(ti, 1'b1);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    chk("tlbr_c1_allowin", ms_if.ws_allowin, 1'b0);
    chk("tlbr_c1_we", tlbr_we, 1'b0);
    chk("tlbr_r_index", tlb_r_index, 4'd7);
    tick();
    chk("tlbr_c2_allowin", ms_if.ws_allowin, 1'b0);
    chk("tlbr_c2_we", tlbr_we, 1'b0);
    tick();
    chk("tlbr_c3_we", tlbr_we, 1'b1);
    chk("tlbr_c3_data", tlbr_data, rd);
    chk("tlbr_c3_allowin", ms_if.ws_allowin, 1'b1);
    chk("tlbr_c3_noflush", flush, 1'b0);
    tick();
    chk("tlbr_flush", flush, 1'b1);
    chk("tlbr_flush_pc", flush_pc, 32'h3004);
    tick();

    // Reset during the TLBR wait.
    drive(ti, 1'b1);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rstw_tlbr_we", tlbr_we, 1'b0);
    chk("rstw_allowin", ms_if.ws_allowin, 1'b1);
    chk("rstw_flush", {flush, flush_pc}, 33'h0);
    reset = 1'b0;
    tick();
    chk("rstw_after_we", tlbr_we, 1'b0);
    chk("rstw_after_flush", flush, 1'b0);

    // TLBR carrying an exception retires at once.
    ti = nop; ti.tlbr = 1'b1; ti.ex = 1'b1; ti.pc = 32'h3100;
    drive(ti, 1'b1);
    tick();
    ms_if.ms_to_ws_valid = 1'b0;
    chk("tlbrx_wb_ex", wb_ex, 1'b1);
    chk("tlbrx_tlbr_we", tlbr_we, 1'b0);
    chk("tlbrx_allowin", ms_if.ws_allowin, 1'b1);
    tick();
    chk("tlbrx_flush_pc", {flush, flush_pc}, {1'b1, EXV});
    tick();

    // Random traffic against a model that tracks only retire and drop cycles.
    reset = 1'b1;
    drive(nop, 1'b0);
    tick(); tick();
    reset = 1'b0;
    cyc = 0; have = 0; drop_until = -1; flush_cyc = -1; exp_fpc = '0; ret_cyc = 0; held = nop;
    for (int k = 0; k < 600; k++) begin
      tick();
      cyc++;
      c0_rdata  = $urandom;
      cp0_epc   = $urandom;
      cp0_index = $urandom;
      tlb_rdata = 78'({$urandom, $urandom, $urandom});
      nx = rnd_instr();
      v  = ($urandom_range(0, 3) != 0);
      drive(nx, v);
      #1;
      retiring = have && (ret_cyc == cyc);
      ok_in    = !have || retiring;
      chk("r_allowin", ms_if.ws_allowin, ok_in);
      chk("r_rf_we", rf_we, retiring && held.gr_we && !held.ex);
      if (retiring && held.gr_we && !held.ex) begin
        chk("r_rf_wdata", rf_wdata, held.cp0_op ? c0_rdata : held.result);
        chk("r_rf_waddr", rf_waddr, held.dest);
        chk("r_dbg_wen", debug_wb_rf_wen, 4'hf);
      end
      chk("r_mtc0_we", mtc0_we, retiring && held.cp0_we && !held.ex);
      chk("r_tlb_we", tlb_we, retiring && held.tlbwi && !held.ex);
      chk("r_tlb_r_index", tlb_r_index, cp0_index[IDX_W-1:0]);
      chk("r_tlbr_we", tlbr_we, retiring && held.tlbr && !held.ex);
      if (retiring && held.tlbr && !held.ex) chk("r_tlbr_data", tlbr_data, tlb_rdata);
      chk("r_tlbp_we", tlbp_we, retiring && held.tlbp && !held.ex);
      if (retiring && held.tlbp && !held.ex)
        chk("r_tlbp", {tlbp_p, tlbp_index}, {!held.s1_found, held.s1_index});
      chk("r_wb_ex", wb_ex, retiring && held.ex);
      chk("r_wb_eret", wb_eret, retiring && held.eret && !held.ex);
      chk("r_flush", flush, flush_cyc == cyc);
      if (flush_cyc == cyc) chk("r_flush_pc", flush_pc, exp_fpc);
      if (retiring) begin
        have = 0;
        if (held.ex || held.eret || held.tlbr || held.tlbwi) begin
          flush_cyc  = cyc + 1;
          drop_until = cyc + 1;
          if (held.ex && held.refill) exp_fpc = RFV;
          else if (held.ex)           exp_fpc = EXV;
          else if (held.eret)         exp_fpc = cp0_epc;
          else                        exp_fpc = held.pc + 32'd4;
        end
      end
      if (v && ok_in && cyc > drop_until) begin
        have    = 1;
        held    = nx;
        ret_cyc = cyc + 1 + ((nx.tlbr && !nx.ex) ? LAT : 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_commit_stage.md
# wb_commit_stage

Parametrised write-back/commit stage for the MIPS pipeline, the final stage after the memory stage. It holds one instruction and retires it: register-file write, CP0 write, exception/ERET reporting, TLBP/TLBR/TLBWI commit. Unlike the single-cycle predecessor, it has a multi-cycle TLBR wait sequencer for a synchronous TLB read port. The pipeline-flush request and redirect PC are registered and issued as a one-cycle pulse. TLB depth and exception vectors are parameters.

## Interface
- TLBNUM, 16: TLB entries; IDX_W = $clog2(TLBNUM).
- TLB_RD_LAT, 1: TLB read latency in cycles, 1..3.
- EX_VEC, 32'hbfc00380: general exception vector.
- REFILL_VEC, 32'hbfc00200: TLB-refill vector.
- clk  in  1  clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- ms_to_ws_valid  in  1  upstream valid.
- ws_allowin  out  1  stage can accept this cycle.
- ms_pc, ms_result, ms_badvaddr  in  32 each  PC, ALU/load result, bad vaddr.
- ms_gr_we, ms_cp0_op, ms_cp0_we  in  1 each  GPR write, MFC0, MTC0.
- ms_dest  in  5  GPR index. ms_cp0_addr  in  8  {rd,sel}.
- ms_ex, ms_refill, ms_bd, ms_eret  in  1 each  exception, TLB-refill class, delay slot, ERET.
- ms_excode  in  5  exception code.
- ms_tlbp, ms_tlbr, ms_tlbwi  in  1 each  TLB op.
- ms_s1_found  in  1, ms_s1_index  in  IDX_W  TLBP probe result.
- rf_we  out 1, rf_waddr  out 5, rf_wdata  out 32  GPR write port.
- mtc0_we  out 1, c0_addr  out 8, c0_wdata  out 32, c0_rdata  in 32  CP0 access.
- wb_ex, wb_bd, wb_eret  out 1 each; ex_type  out 5; wb_pc, wb_badvaddr  out 32  CP0 exception report.
- cp0_epc  in 32, cp0_index  in 32  CP0 state.
- tlb_we  out 1, tlb_w_index  out IDX_W  TLBWI write strobe and index.
- tlb_r_index  out IDX_W  TLB read index.
- tlb_rdata  in 78  {vpn2,asid,g,pfn0,c0,d0,v0,pfn1,c1,d1,v1}.
- tlbr_we  out 1, tlbr_data  out 78  TLBR result load into CP0.
- tlbp_we  out 1, tlbp_p  out 1, tlbp_index  out IDX_W  TLBP result to Index.
- flush  out 1, flush_pc  out 32  registered redirect.
- debug_wb_pc  out 32, debug_wb_rf_wen  out 4, debug_wb_rf_wnum  out 5, debug_wb_rf_wdata  out 32  trace port.

## Operation
- One payload register, loaded when ms_to_ws_valid && ws_allowin && !flush. ws_valid clears when the held instruction retires and nothing is loaded, on reset, and in any cycle flush=1.
- ws_allowin = !ws_valid || retire. retire = ws_valid && ready_go.
- ready_go = 1, except for a TLBR without exception:
  - IDLE→WAIT on entry; the counter loads TLB_RD_LAT.
  - WAIT decrements the counter each cycle. ready_go=1 when it reaches 0, then WAIT→IDLE.
- tlb_r_index = cp0_index[IDX_W-1:0] throughout.
- Qualifiers (all gated by retire && !ms_ex):
  - rf_we = retire && ms_gr_we && !ms_ex; rf_wdata = ms_cp0_op ? c0_rdata : ms_result.
  - mtc0_we and tlb_we (on TLBWI, index cp0_index[IDX_W-1:0]).
  - tlbr_we (tlbr_data = tlb_rdata sampled in the retire cycle).
  - tlbp_we, with tlbp_p = !ms_s1_found and tlbp_index = ms_s1_index.
- wb_ex = retire && ms_ex; exceptions suppress every write. wb_eret = retire && ms_eret && !ms_ex.
- Flush source: retire && (ms_ex || ms_eret || ms_tlbr || ms_tlbwi). flush_pc is chosen in priority order:
  - ms_ex && ms_refill → REFILL_VEC.
  - ms_ex → EX_VEC.
  - eret → cp0_epc.
  - otherwise → ms_pc+4.
- flush and flush_pc are registered and pulse for one cycle. Input offered in the flush cycle is dropped.
- Debug outputs mirror the rf_* outputs, with debug_wb_rf_wen = {4{rf_we}}.

## Timing
- Reset: ws_valid=0, state=IDLE, counter=0, flush=0, flush_pc=0. All strobes (rf_we, mtc0_we, tlb_we, tlbr_we, tlbp_we, wb_ex, wb_eret) are 0.
- Normal instruction: accepted at edge N, retires in cycle N (strobes combinational), throughput 1/cycle.
- TLBR: held TLB_RD_LAT extra cycles; ws_allowin=0 while waiting. tlbr_we is asserted in the last cycle; flush follows one cycle later.
- Flush-causing retire in cycle R: flush=1 in cycle R+1 only, and ws_valid=0 in R+1.
- Reset mid-WAIT returns to IDLE with no tlbr_we.
- Exception on a TLBR: no WAIT, retires immediately.

## Test plan
- ADDU dest=5, result=32'h1234 back-to-back with dest=6 → rf_we in consecutive cycles, debug_wb_rf_wen=4'hf, no flush.
- MFC0 with c0_rdata=32'hdead_beef, dest=3 → rf_wdata=32'hdeadbeef.
- Load with ms_ex=1, ms_refill=1, pc=32'h8000_0100 → wb_ex=1, rf_we=0. Next cycle flush=1, flush_pc=32'hbfc00200; the input offered that cycle is dropped.
- TLBR with TLB_RD_LAT=2, cp0_index=7 → ws_allowin=0 for 2 cycles and tlb_r_index=7. tlbr_we comes in cycle 3 with tlb_rdata; the following cycle has flush_pc=pc+4.
- TLBP with s1_found=0, index=4 → tlbp_we=1, tlbp_p=1, tlbp_index=4, no flush.
- ERET with cp0_epc=32'hbfc0_1000 → wb_eret=1, then flush_pc=32'hbfc01000. Asserting reset during a TLBR WAIT → no tlbr_we, and outputs return to reset values.
